// File: rtl/shift_issue_ctrl_pkg.sv
// Shared constants and types for the shift issue/collect stage and its shifter.
package shift_issue_ctrl_pkg;

  localparam int WIDTH      = 32;
  localparam int SHW        = 5;
  localparam int SHIFT_LAT  = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int TAG_W      = 4;
  localparam int CRED_W     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    OP_SRL = 2'b00,
    OP_ROR = 2'b01,
    OP_SLL = 2'b10,
    OP_ROL = 2'b11
  } op_e;

  // One shadow-pipe slot: tracks an op travelling through the shifter.
  typedef struct packed {
    logic             valid;
    logic             rev;
    logic [TAG_W-1:0] tag;
  } shadow_t;

endpackage

// File: rtl/shift_issue_ctrl_chk.sv
// Simulation-only invariants of the issue stage: the result FIFO is never
// written while full, and the credit counter stays within its range.
module shift_issue_ctrl_chk
  import shift_issue_ctrl_pkg::*;
(
  input logic              clk,
  input logic              rst,
  input logic              wr_en,
  input logic              full,
  input logic [CRED_W-1:0] credits
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

  a_credit_range: assert property (@(posedge clk) disable iff (rst)
                                   credits <= CRED_W'(FIFO_DEPTH));

endmodule

// File: rtl/shift_issue_ctrl_fifo.sv
// In-order result FIFO, not fall-through: a written entry is visible the cycle
// after the write. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [AW:0]   count_r, count_nxt_s;
  logic          full_r, valid_r;
  logic          do_wr_s, do_rd_s;

  assign do_wr_s = wr_en & ~full_r;
  assign do_rd_s = rd_en & valid_r;

  // Occupancy after this cycle's write and read.
  always_comb begin
    count_nxt_s = count_r;
    if (do_wr_s && !do_rd_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (do_rd_s && !do_wr_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy and registered full/valid flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      full_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      valid_r <= (count_nxt_s != CNT_ZERO);
    end
  end

  // Storage array; contents need no reset because valid_r gates them.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data  = mem_r[rd_ptr_r];
  assign rd_valid = valid_r;
  assign full     = full_r;

endmodule

// File: rtl/shifter.sv
// Five-stage pipelined right shifter/rotator. Stage k applies the 16/8/4/2/1
// step selected by the matching amount bit. Registers are intentionally not
// reset: the issue stage tracks validity separately and ignores stale data.
module shifter
  import shift_issue_ctrl_pkg::*;
(
  input  logic [0:0]       clk,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sel,
  input  logic             rotate,
  output logic [WIDTH-1:0] b
);

  logic [WIDTH-1:0] d1_r, d2_r, d3_r, d4_r, d5_r;
  logic [3:0]       sel1_r;
  logic [2:0]       sel2_r;
  logic [1:0]       sel3_r;
  logic             sel4_r;
  logic             rot1_r, rot2_r, rot3_r, rot4_r;

  // One conditional right step by k bits; rotate wraps the dropped bits to the top.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x, input logic en,
                                            input logic rot, input int k);
    logic [WIDTH-1:0] r;
    if (!en) begin
      r = x;
    end else if (rot) begin
      r = (x >> k) | (x << (WIDTH - k));
    end else begin
      r = x >> k;
    end
    return r;
  endfunction

  // Pipeline advances every cycle; amount bits are dropped once consumed.
  always_ff @(posedge clk) begin
    d1_r   <= step(a, sel[4], rotate, 16);
    sel1_r <= sel[3:0];
    rot1_r <= rotate;
    d2_r   <= step(d1_r, sel1_r[3], rot1_r, 8);
    sel2_r <= sel1_r[2:0];
    rot2_r <= rot1_r;
    d3_r   <= step(d2_r, sel2_r[2], rot2_r, 4);
    sel3_r <= sel2_r[1:0];
    rot3_r <= rot2_r;
    d4_r   <= step(d3_r, sel3_r[1], rot3_r, 2);
    sel4_r <= sel3_r[0];
    rot4_r <= rot3_r;
    d5_r   <= step(d4_r, sel4_r, rot4_r, 1);
  end

  assign b = d5_r;

endmodule

// File: rtl/shift_issue_ctrl.sv
// Issue/collect stage around the pipelined shifter. Left ops are done as right
// ops on a bit-reversed operand, reversed back on capture. A shadow pipe
// follows each op through the shifter; credits keep the result FIFO from
// overflowing because the shifter can never stall.
module shift_issue_ctrl
  import shift_issue_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [SHW-1:0]   req_amt,
  input  logic [1:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic [WIDTH-1:0] sh_a,
  output logic [SHW-1:0]   sh_sel,
  output logic             sh_rotate,
  input  logic [WIDTH-1:0] sh_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int FW = WIDTH + TAG_W;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);
  localparam logic [CRED_W-1:0] CRED_NIL = CRED_W'(0);
  localparam shadow_t SHADOW_IDLE = '{valid: 1'b0, rev: 1'b0, tag: {TAG_W{1'b0}}};

  logic [CRED_W-1:0]     credits_r, credits_nxt_s;
  logic                  ready_r, busy_r;
  logic                  fire_s, pop_s;
  logic [WIDTH-1:0]      issue_a_s;
  logic [WIDTH-1:0]      sh_a_r;
  logic [SHW-1:0]        sh_sel_r;
  logic                  sh_rotate_r;
  shadow_t               shadow_in_s;
  shadow_t [SHIFT_LAT:0] shadow_r;
  shadow_t               shadow_last_s;
  logic                  wr_en_s;
  logic [WIDTH-1:0]      cap_data_s;
  logic [FW-1:0]         wr_data_s, rd_data_s;
  logic                  fifo_full_s, rd_valid_s;

  // Mirror-image of a word: bit i moves to bit WIDTH-1-i.
  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  assign fire_s = req_valid & ready_r;
  assign pop_s  = rd_valid_s & rsp_ready;

  // Credit count after this cycle's accept and pop; both together cancel.
  always_comb begin
    credits_nxt_s = credits_r;
    if (fire_s && !pop_s) begin
      credits_nxt_s = credits_r - CRED_ONE;
    end else if (pop_s && !fire_s) begin
      credits_nxt_s = credits_r + CRED_ONE;
    end else begin
      credits_nxt_s = credits_r;
    end
  end

  // Credit counter with registered ready/busy flags derived from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits_r <= CRED_MAX;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      credits_r <= credits_nxt_s;
      ready_r   <= (credits_nxt_s != CRED_NIL);
      busy_r    <= (credits_nxt_s != CRED_MAX);
    end
  end

  // Left ops enter the shifter bit-reversed.
  always_comb begin
    issue_a_s = req_data;
    if (req_op[1]) begin
      issue_a_s = bitrev(req_data);
    end else begin
      issue_a_s = req_data;
    end
  end

  // Issue register feeding the shifter; holds its value when nothing fires.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_a_r      <= {WIDTH{1'b0}};
      sh_sel_r    <= {SHW{1'b0}};
      sh_rotate_r <= 1'b0;
    end else if (fire_s) begin
      sh_a_r      <= issue_a_s;
      sh_sel_r    <= req_amt;
      sh_rotate_r <= req_op[0];
    end
  end

  assign shadow_in_s = '{valid: fire_s, rev: req_op[1], tag: req_tag};

  // Shadow pipe: one slot per cycle of shifter latency plus the issue register.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_r <= {(SHIFT_LAT + 1){SHADOW_IDLE}};
    end else begin
      shadow_r <= {shadow_r[SHIFT_LAT-1:0], shadow_in_s};
    end
  end

  assign shadow_last_s = shadow_r[SHIFT_LAT];
  assign wr_en_s       = shadow_last_s.valid;

  // Undo the operand reversal for left ops as the result is captured.
  always_comb begin
    cap_data_s = sh_b;
    if (shadow_last_s.rev) begin
      cap_data_s = bitrev(sh_b);
    end else begin
      cap_data_s = sh_b;
    end
  end

  assign wr_data_s = {shadow_last_s.tag, cap_data_s};

  sync_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en_s),
    .wr_data  (wr_data_s),
    .full     (fifo_full_s),
    .rd_en    (rsp_ready),
    .rd_data  (rd_data_s),
    .rd_valid (rd_valid_s)
  );

  shift_issue_ctrl_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .full    (fifo_full_s),
    .credits (credits_r)
  );

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign sh_a      = sh_a_r;
  assign sh_sel    = sh_sel_r;
  assign sh_rotate = sh_rotate_r;
  assign rsp_valid = rd_valid_s;
  assign rsp_data  = rd_data_s[WIDTH-1:0];
  assign rsp_tag   = rd_data_s[FW-1 -: TAG_W];

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl together with the shifter. A queue-based model
// predicts every response and when it becomes visible; directed literals pin
// the model on hand-computed cases.
`timescale 1ns/1ps
module tb_shift_issue_ctrl;
  import shift_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, req_valid, req_ready, sh_rotate, rsp_valid, rsp_ready, busy;
  logic [WIDTH-1:0] req_data, sh_a, sh_b, rsp_data;
  logic [SHW-1:0]   req_amt, sh_sel;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag, rsp_tag;

  shift_issue_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_op(req_op), .req_tag(req_tag),
    .sh_a(sh_a), .sh_sel(sh_sel), .sh_rotate(sh_rotate), .sh_b(sh_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .busy(busy)
  );

  shifter u_shifter (.clk(clk), .a(sh_a), .sel(sh_sel), .rotate(sh_rotate), .b(sh_b));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit live     = 1'b0;

  typedef struct { logic [31:0] data; logic [3:0] tag; int ready_at; } exp_t;
  typedef struct { logic [31:0] data; logic [3:0] tag; int seen; } got_t;
  exp_t exp_q[$];
  got_t got_q[$];
  int   acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference result from the op's arithmetic definition.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] amt);
    logic [63:0] dd;
    dd = {d, d};
    case (op)
      2'b00:   return d >> amt;
      2'b01:   begin dd = dd >> amt; return dd[31:0]; end
      2'b10:   return d << amt;
      default: begin dd = dd << amt; return dd[63:32]; end
    endcase
  endfunction

  // Compare process: check outputs against the model, then advance the model
  // with whatever the coming rising edge will do.
  always @(negedge clk) begin
    int   outstanding;
    bit   exp_rv;
    exp_t e;
    got_t g;
    if (rst) begin
      exp_q.delete();
      live = 1'b1;
    end else if (live) begin
      outstanding = exp_q.size();
      exp_rv = (outstanding != 0) && (exp_q[0].ready_at <= cyc);
      check("req_ready", req_ready, outstanding < FIFO_DEPTH);
      check("busy", busy, outstanding != 0);
      check("rsp_valid", rsp_valid, exp_rv);
      if (exp_rv) begin
        check("rsp_data", rsp_data, exp_q[0].data);
        check("rsp_tag", rsp_tag, exp_q[0].tag);
      end
      if (rsp_valid && rsp_ready) begin
        g.data = rsp_data; g.tag = rsp_tag; g.seen = cyc;
        got_q.push_back(g);
      end
      if (exp_rv && rsp_ready) void'(exp_q.pop_front());
      if (req_valid && (outstanding < FIFO_DEPTH)) begin
        e.data = ref_shift(req_op, req_data, req_amt);
        e.tag = req_tag;
        e.ready_at = cyc + 1 + SHIFT_LAT + 1;
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] amt,
                       input logic [3:0] tag);
    bit done = 1'b0;
    req_valid = 1'b1; req_op = op; req_data = d; req_amt = amt; req_tag = tag;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      done = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) check("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) check("drain_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string name, input int idx, input logic [31:0] d,
                           input logic [3:0] t);
    if (idx < got_q.size()) begin
      check({name, "_data"}, got_q[idx].data, d);
      check({name, "_tag"}, got_q[idx].tag, t);
    end else begin
      check({name, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, abase, n_acc;
    bit acc;
    rst = 1'b1; req_valid = 1'b0; req_data = '0; req_amt = '0; req_op = '0;
    req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_req_ready", req_ready, 64'd1);
    check("rst_rsp_valid", rsp_valid, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_sh_a", sh_a, 64'd0);
    check("rst_sh_sel", sh_sel, 64'd0);
    check("rst_sh_rotate", sh_rotate, 64'd0);

    // 1: single SRL with latency
    base = got_q.size(); abase = acc_q.size();
    issue(OP_SRL, 32'h8000_0001, 5'd4, 4'd3);
    drain();
    check_rsp("t1", base, 32'h0800_0000, 4'd3);
    if (got_q.size() > base && acc_q.size() > abase)
      check("t1_latency", got_q[base].seen - acc_q[abase], 64'd6);
    else
      check("t1_latency_missing", 64'd0, 64'd1);

    // 2: rotate and left ops
    base = got_q.size();
    issue(OP_ROR, 32'h0000_00F1, 5'd4, 4'd1);
    issue(OP_SLL, 32'h0000_0001, 5'd31, 4'd2);
    issue(OP_ROL, 32'h8000_0001, 5'd1, 4'd4);
    drain();
    check_rsp("t2_ror", base, 32'h1000_000F, 4'd1);
    check_rsp("t2_sll", base + 1, 32'h8000_0000, 4'd2);
    check_rsp("t2_rol", base + 2, 32'h0000_0003, 4'd4);

    // 3: 16 back-to-back random requests at full rate
    base = got_q.size(); abase = acc_q.size();
    for (int k = 0; k < 16; k++)
      issue(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 4'(k));
    drain();
    check("t3_count", got_q.size() - base, 64'd16);
    if (got_q.size() >= base + 16 && acc_q.size() >= abase + 16) begin
      check("t3_accept_span", acc_q[abase + 15] - acc_q[abase], 64'd15);
      check("t3_rsp_span", got_q[base + 15].seen - got_q[base].seen, 64'd15);
      check("t3_last_tag", got_q[base + 15].tag, 64'd15);
    end else begin
      check("t3_span_missing", 64'd0, 64'd1);
    end

    // 4: consumer stalled, credits exhausted, then drained
    base = got_q.size();
    rsp_ready = 1'b0; n_acc = 0; req_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      req_op = OP_SLL; req_amt = 5'd4; req_data = 32'(n_acc + 1); req_tag = 4'(n_acc);
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) n_acc++;
    end
    req_valid = 1'b0;
    check("t4_accepted", n_acc, 64'd8);
    check("t4_ready_low", req_ready, 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t4_head_valid", rsp_valid, 64'd1);
    check("t4_head_data", rsp_data, 64'h10);
    check("t4_head_tag", rsp_tag, 64'd0);
    check("t4_ready_still_low", req_ready, 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_ready_after_pop", req_ready, 64'd1);
    drain();
    check("t4_count", got_q.size() - base, 64'd8);
    check_rsp("t4_last", base + 7, 32'h0000_0080, 4'd7);

    // 5: reset with ops in flight
    base = got_q.size();
    issue(OP_SRL, 32'h1234_5678, 5'd8, 4'd9);
    issue(OP_ROL, 32'h1234_5678, 5'd8, 4'd10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_rsp", got_q.size() - base, 64'd0);
    check("t5_rsp_valid", rsp_valid, 64'd0);
    check("t5_req_ready", req_ready, 64'd1);
    check("t5_busy", busy, 64'd0);
    issue(OP_SRL, 32'hFFFF_FFFF, 5'd16, 4'd5);
    drain();
    check_rsp("t5_after", base, 32'h0000_FFFF, 4'd5);

    // 6: amount zero leaves the operand unchanged for every op
    base = got_q.size();
    for (int k = 0; k < 4; k++) issue(2'(k), 32'hA5A5_0F0F, 5'd0, 4'(k + 8));
    drain();
    check_rsp("t6_srl", base,     32'hA5A5_0F0F, 4'd8);
    check_rsp("t6_ror", base + 1, 32'hA5A5_0F0F, 4'd9);
    check_rsp("t6_sll", base + 2, 32'hA5A5_0F0F, 4'd10);
    check_rsp("t6_rol", base + 3, 32'hA5A5_0F0F, 4'd11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
